// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full-adder slice (two half adders
// plus an OR for carry) walks the operands LSB-first, one bit per clock.
//
// Handshake: start is a request sampled only while idle (busy=0). The edge
// that samples start=1 in IDLE captures a/b. start while busy is ignored,
// with no queuing. done is a one-cycle pulse that marks sum/cout as the new
// result. sum/cout then hold until the next completion or reset.

// Half adder used as the building block of the shared slice.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);
  // Combinational sum/carry of two bits.
  assign sum  = a ^ b;
  assign cout = a & b;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Shared 1-bit full-adder slice.
  logic half_s, half_c0, slice_s, half_c1, slice_c;

  half_adder u_ha0 (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .sum  (half_s),
    .cout (half_c0)
  );

  half_adder u_ha1 (
    .a    (half_s),
    .b    (carry_q),
    .sum  (slice_s),
    .cout (half_c1)
  );

  assign slice_c = half_c0 | half_c1;

  // Next-state and datapath control; every variable defaults to hold.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = 1'b0;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // New bit enters at the MSB so after WIDTH steps bit 0 sits at LSB.
        acc_d   = (acc_q >> 1) | (WIDTH'(slice_s) << (WIDTH - 1));
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = slice_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = acc_d;
          cout_d  = slice_c;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are registered values or decodes of the registered state.
  assign busy = (state_q == RUN) || (state_q == DONE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: a WIDTH=8 and a WIDTH=1 instance on one clock.
// Expected results come from plain a+b arithmetic and the documented timing.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected {cout,sum} for accepted 8-bit operations.
  logic [8:0] exp_q[$];
  // Result the 8-bit instance is expected to be holding.
  logic [7:0] hold_sum;
  logic       hold_cout;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      errors++;
      $display("FAIL reset8 got busy=%0b done=%0b cout=%0b sum=%h want all zero",
               busy8, done8, cout8, sum8);
    end
    checks++;
    if ({busy1, done1, cout1, sum1} !== 4'd0) begin
      errors++;
      $display("FAIL reset1 got busy=%0b done=%0b cout=%0b sum=%h want all zero",
               busy1, done1, cout1, sum1);
    end
    hold_sum = 8'h00; hold_cout = 1'b0;
  endtask

  // One 8-bit operation from IDLE; operands are scrambled during RUN.
  task automatic run_op8(input logic [7:0] op_a, input logic [7:0] op_b);
    logic [8:0] exp;
    exp_q.push_back({1'b0, op_a} + {1'b0, op_b});
    start8 = 1'b1; a8 = op_a; b8 = op_b;
    @(negedge clk);
    start8 = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (busy8 !== 1'b1 || done8 !== (k == 8)) begin
        errors++;
        $display("FAIL op_timing k=%0d got busy=%0b done=%0b want busy=1 done=%0b",
                 k, busy8, done8, (k == 8));
      end
      if (k < 8) begin
        checks++;
        if ({cout8, sum8} !== {hold_cout, hold_sum}) begin
          errors++;
          $display("FAIL op_hold k=%0d got %h want %h", k, {cout8, sum8},
                   {hold_cout, hold_sum});
        end
      end else begin
        exp = exp_q.pop_front();
        checks++;
        if ({cout8, sum8} !== exp) begin
          errors++;
          $display("FAIL op_result a=%h b=%h got %h want %h", op_a, op_b,
                   {cout8, sum8}, exp);
        end
        hold_cout = exp[8]; hold_sum = exp[7:0];
      end
      a8 = 8'($urandom); b8 = 8'($urandom);
    end
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || {cout8, sum8} !== {hold_cout, hold_sum}) begin
      errors++;
      $display("FAIL op_after got busy=%0b done=%0b res=%h want 0 0 %h",
               busy8, done8, {cout8, sum8}, {hold_cout, hold_sum});
    end
  endtask

  task automatic test_directed;
    run_op8(8'h00, 8'h00);
    run_op8(8'hFF, 8'h01);
    run_op8(8'h5A, 8'h3C);
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op8(8'($urandom), 8'($urandom));
    end
  endtask

  task automatic test_start_while_busy;
    int n_done;
    n_done = 0;
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20;
    @(negedge clk);
    start8 = 1'b0;
    for (int k = 0; k < 22; k++) begin
      if (k > 0) @(negedge clk);
      start8 = (k == 2);
      if (k == 2) begin a8 = 8'hFF; b8 = 8'hFF; end
      if (done8) begin
        n_done++;
        checks++;
        if (k != 8 || {cout8, sum8} !== 9'h030) begin
          errors++;
          $display("FAIL busy_ignore k=%0d got %h want k=8 res=030", k, {cout8, sum8});
        end
      end
    end
    start8 = 1'b0;
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL busy_done_count got %0d want 1", n_done);
    end
    hold_sum = 8'h30; hold_cout = 1'b0;
  endtask

  task automatic test_reset_mid_op;
    int n_done;
    n_done = 0;
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      errors++;
      $display("FAIL abort_state got busy=%0b done=%0b cout=%0b sum=%h want all zero",
               busy8, done8, cout8, sum8);
    end
    hold_sum = 8'h00; hold_cout = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 || busy8) n_done++;
    end
    checks++;
    if (n_done != 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d busy/done cycles want 0", n_done);
    end
    run_op8(8'h01, 8'h01);
  endtask

  task automatic test_back_to_back;
    int n_done, last_c;
    n_done = 0; last_c = -1;
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h80;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      if (done8) begin
        n_done++;
        checks++;
        if ((last_c < 0 && c != 9) || (last_c >= 0 && c - last_c != 10) ||
            {cout8, sum8} !== 9'h100) begin
          errors++;
          $display("FAIL b2b cycle=%0d prev=%0d res=%h want period 10 res=100",
                   c, last_c, {cout8, sum8});
        end
        last_c = c;
      end
    end
    start8 = 1'b0;
    checks++;
    if (n_done != 3) begin
      errors++;
      $display("FAIL b2b_count got %0d want 3", n_done);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || {cout8, sum8} !== 9'h100) begin
      errors++;
      $display("FAIL b2b_drain got busy=%0b res=%h want 0 100", busy8, {cout8, sum8});
    end
    hold_sum = 8'h00; hold_cout = 1'b1;
  endtask

  task automatic test_width1;
    logic [1:0] exp;
    for (int i = 0; i < 4; i++) begin
      start1 = 1'b1; a1 = 1'(i >> 1); b1 = 1'(i);
      exp = 2'(a1) + 2'(b1);
      @(negedge clk);
      start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom);
      checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        errors++;
        $display("FAIL w1_run i=%0d got busy=%0b done=%0b want 1 0", i, busy1, done1);
      end
      @(negedge clk);
      checks++;
      if (done1 !== 1'b1 || {cout1, sum1} !== exp) begin
        errors++;
        $display("FAIL w1_result i=%0d got done=%0b res=%b want 1 %b", i, done1,
                 {cout1, sum1}, exp);
      end
      @(negedge clk);
      checks++;
      if (busy1 !== 1'b0 || done1 !== 1'b0) begin
        errors++;
        $display("FAIL w1_idle i=%0d got busy=%0b done=%0b want 0 0", i, busy1, done1);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_start_while_busy;
    test_reset_mid_op;
    test_back_to_back;
    test_random;
    test_width1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
